transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/uart_pkg.sv | 29 ++
 rtl/transmitter_if.sv | 27 ++
 rtl/transmitter_crc.sv | 24 ++
 rtl/transmitter.sv | 190 +++++++++++++++++++
 tb/tb_transmitter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared transmitter/receiver definitions: frame FSM states, field widths and
// the serial CRC-8 step (polynomial x^8+x^2+x+1).
package uart_pkg;

  localparam int SIZE_W = 4;
  localparam int BYTE_W = 8;
  localparam int BAUD_W = 8;
  localparam int CRC_W  = 8;

  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SIZE,
    ST_DATA,
    ST_CRC,
    ST_STOP
  } txState_t;

  // One MSB-first shift of the CRC register with the incoming line bit.
  function automatic logic [CRC_W-1:0] crcStep(input logic [CRC_W-1:0] crcIn,
                                               input logic bitIn);
    logic fb;
    fb = bitIn ^ crcIn[CRC_W-1];
    return {crcIn[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/transmitter_if.sv
// Frame request, byte-feed handshake and serial-line signals of the transmitter.
// The master side is the byte source / controller, the slave side is the transmitter.
interface transmitter_if;
  import uart_pkg::*;

  logic [BAUD_W-1:0] baudrate;
  logic              start;
  logic [SIZE_W-1:0] framesize;
  logic [BYTE_W-1:0] datain;
  logic              dvalid;
  logic              dready;
  logic              TX;
  logic              busy;
  logic              done;
  logic              ur;

  modport master (
    output baudrate, start, framesize, datain, dvalid,
    input  dready, TX, busy, done, ur
  );

  modport slave (
    input  baudrate, start, framesize, datain, dvalid,
    output dready, TX, busy, done, ur
  );

endinterface

// File: rtl/transmitter_crc.sv
// Serial CRC-8 accumulator shared with the receiver; one bit per enabled clock.
module crc
  import uart_pkg::*;
(
  input  logic             enable,
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [CRC_W-1:0] out
);

  logic [CRC_W-1:0] r_crc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= '0;
    end else if (enable) begin
      r_crc <= crcStep(r_crc, in);
    end
  end

  assign out = r_crc;

endmodule

// File: rtl/transmitter.sv
// Framed serial transmitter: start bit, 4-bit size, N data bytes, CRC-8, stop bit.
// Define TX_BITSTUFF_EN to insert a 0 after every five consecutive 1s in SIZE/DATA/CRC.
module transmitter
  import uart_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  transmitter_if.slave  bus
);

  txState_t          r_state, w_stateNext;
  logic [BAUD_W-1:0] r_baudCnt, w_baudCntNext, w_baudEff;
  logic [2:0]        r_bitCnt, w_bitCntNext;
  logic [SIZE_W-1:0] r_byteCnt, w_byteCntNext, r_size, r_accepted;
  logic [BYTE_W-1:0] r_shift, w_shiftNext, r_hold, w_byte;
  logic              r_holdFull, r_tx, w_txNext, r_done, w_doneNext, r_ur;
  logic              w_bitEnd, w_startAccept, w_accept, w_needByte;
  logic              w_crcEn, w_crcClear, w_stuffNow;
  logic [CRC_W-1:0]  w_crcOut;

  assign w_baudEff = (bus.baudrate == '0) ? 8'd1 : bus.baudrate;
  assign w_bitEnd  = (r_baudCnt >= w_baudEff - 8'd1);
  assign w_accept  = bus.dvalid && bus.dready;
  // A byte handed over on the very edge it is needed goes straight to the line.
  assign w_byte    = r_holdFull ? r_hold : (w_accept ? bus.datain : '0);

  assign bus.dready = (r_state != ST_IDLE) && !r_holdFull && (r_accepted < r_size);
  assign bus.TX     = r_tx;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = r_done;
  assign bus.ur     = r_ur;

`ifdef TX_BITSTUFF_EN
  logic [2:0] r_ones;

  assign w_stuffNow = w_bitEnd && (r_state inside {ST_SIZE, ST_DATA, ST_CRC}) &&
                      (r_ones == 3'd5);

  always_ff @(posedge clk) begin
    if (reset || w_startAccept || w_stuffNow) begin
      r_ones <= '0;
    end else if (w_bitEnd && (w_stateNext inside {ST_SIZE, ST_DATA, ST_CRC})) begin
      r_ones <= w_txNext ? r_ones + 3'd1 : 3'd0;
    end
  end
`else
  assign w_stuffNow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Everything advances only at a bit boundary; a stuff bit freezes field position.
  always_comb begin
    w_stateNext   = r_state;
    w_txNext      = r_tx;
    w_shiftNext   = r_shift;
    w_bitCntNext  = r_bitCnt;
    w_byteCntNext = r_byteCnt;
    w_baudCntNext = r_baudCnt + 8'd1;
    w_startAccept = 1'b0;
    w_needByte    = 1'b0;
    w_crcEn       = 1'b0;
    w_doneNext    = 1'b0;
    if (r_state == ST_IDLE) begin
      w_baudCntNext = '0;
      w_txNext      = 1'b0;
      w_byteCntNext = '0;
      if (bus.start && !r_done) begin
        w_startAccept = 1'b1;
        w_stateNext   = ST_START;
        w_txNext      = 1'b1;
      end
    end else if (w_bitEnd) begin
      w_baudCntNext = '0;
      if (w_stuffNow) begin
        w_txNext = 1'b0;
      end else begin
        case (r_state)
          ST_START: begin
            w_stateNext  = ST_SIZE;
            w_shiftNext  = {r_size, 4'b0000};
            w_txNext     = r_size[3];
            w_bitCntNext = 3'd3;
            w_crcEn      = 1'b1;
          end
          ST_SIZE, ST_DATA: begin
            if (r_bitCnt != 3'd0) begin
              w_shiftNext  = r_shift << 1;
              w_txNext     = r_shift[6];
              w_bitCntNext = r_bitCnt - 3'd1;
              w_crcEn      = 1'b1;
            end else if (r_byteCnt == r_size) begin
              w_stateNext  = ST_CRC;
              w_shiftNext  = w_crcOut;
              w_txNext     = w_crcOut[7];
              w_bitCntNext = 3'd7;
            end else begin
              w_stateNext   = ST_DATA;
              w_needByte    = 1'b1;
              w_shiftNext   = w_byte;
              w_txNext      = w_byte[7];
              w_bitCntNext  = 3'd7;
              w_byteCntNext = r_byteCnt + 4'd1;
              w_crcEn       = 1'b1;
            end
          end
          ST_CRC: begin
            if (r_bitCnt != 3'd0) begin
              w_shiftNext  = r_shift << 1;
              w_txNext     = r_shift[6];
              w_bitCntNext = r_bitCnt - 3'd1;
            end else begin
              w_stateNext = ST_STOP;
              w_txNext    = 1'b0;
            end
          end
          ST_STOP: begin
            w_stateNext = ST_IDLE;
            w_txNext    = 1'b0;
            w_doneNext  = 1'b1;
          end
          default: begin
            w_stateNext = ST_IDLE;
            w_txNext    = 1'b0;
          end
        endcase
      end
    end
  end

  // An underrun still consumes its byte slot so the byte count stays aligned to N.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baudCnt  <= '0;
      r_tx       <= 1'b0;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_byteCnt  <= '0;
      r_done     <= 1'b0;
      r_size     <= '0;
      r_accepted <= '0;
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_ur       <= 1'b0;
    end else begin
      r_baudCnt <= w_baudCntNext;
      r_tx      <= w_txNext;
      r_shift   <= w_shiftNext;
      r_bitCnt  <= w_bitCntNext;
      r_byteCnt <= w_byteCntNext;
      r_done    <= w_doneNext;
      if (w_startAccept) begin
        r_size     <= bus.framesize;
        r_accepted <= '0;
        r_holdFull <= 1'b0;
        r_ur       <= 1'b0;
      end else if (w_needByte) begin
        if (r_holdFull) begin
          r_holdFull <= 1'b0;
        end else begin
          r_accepted <= r_accepted + 4'd1;
          if (!w_accept) begin
            r_ur <= 1'b1;
          end
        end
      end else if (w_accept) begin
        r_hold     <= bus.datain;
        r_holdFull <= 1'b1;
        r_accepted <= r_accepted + 4'd1;
      end
    end
  end

  assign w_crcClear = reset || w_startAccept;

  crc u_crc (
    .enable (w_crcEn),
    .clk    (clk),
    .reset  (w_crcClear),
    .in     (w_txNext),
    .out    (w_crcOut)
  );

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for the framed transmitter: stimulus pushes expected frames,
// a monitor captures TX while busy and compares when done pulses.
module tb_transmitter;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;

  transmitter_if bus ();

  transmitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    int           baud;
    int           nbits;
    logic [255:0] bits;
    logic         ur;
  } frameExp_t;

  frameExp_t  expQ[$];
  logic [7:0] txBytes[16];
  int         errors = 0;
  int         checks = 0;

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference frame: size and data bits feed the CRC, stuffing applies after.
  function automatic frameExp_t buildFrame(input int id, input int baud, input int n,
                                           input int skipIdx);
    frameExp_t  e;
    logic       p[$];
    logic [7:0] c;
    logic [7:0] byt;
    logic       fb;
    int         idx;
    int         ones;
    c = 8'h00;
    for (int i = 3; i >= 0; i--) p.push_back(n[i]);
    for (int k = 0; k < n; k++) begin
      byt = (k == skipIdx) ? 8'h00 : txBytes[k];
      for (int i = 7; i >= 0; i--) p.push_back(byt[i]);
    end
    foreach (p[j]) begin
      fb = p[j] ^ c[7];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    for (int i = 7; i >= 0; i--) p.push_back(c[i]);
    e.id    = id;
    e.baud  = (baud == 0) ? 1 : baud;
    e.bits  = '0;
    e.ur    = (skipIdx >= 0) && (skipIdx < n);
    e.bits[0] = 1'b1;
    idx  = 1;
    ones = 0;
    foreach (p[j]) begin
      e.bits[idx] = p[j];
      idx++;
`ifdef TX_BITSTUFF_EN
      ones = p[j] ? ones + 1 : 0;
      if (ones == 5) begin
        e.bits[idx] = 1'b0;
        idx++;
        ones = 0;
      end
`endif
    end
    e.bits[idx] = 1'b0;
    e.nbits = idx + 1;
    return e;
  endfunction

  // Monitor: collects the line while busy; on done, pops and compares one frame.
  initial begin : monitor
    logic      samples[$];
    frameExp_t e;
    int        bad;
    forever begin
      @(negedge clk);
      if (reset) begin
        samples.delete();
      end else begin
        if (bus.busy) samples.push_back(bus.TX);
        if (bus.done) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", bus.done, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("busyCycles[f%0d]", e.id), samples.size(),
                        e.nbits * e.baud);
            bad = -1;
            for (int i = 0; i < samples.size() && i < e.nbits * e.baud; i++) begin
              if (bad < 0 && samples[i] !== e.bits[i / e.baud]) bad = i;
            end
            checkOutput($sformatf("txWaveFirstBadCycle[f%0d]", e.id), bad, -1);
            checkOutput($sformatf("urAtDone[f%0d]", e.id), bus.ur, e.ur);
          end
          samples.delete();
        end
      end
    end
  end

  // One frame: push expectation, feed bytes on dready, optionally poke start or reset.
  task automatic applyStimulus(input int id, input int baud, input int n, input int skipIdx,
                               input int abortAt, input bit poke, input int litLen,
                               input logic [255:0] lit);
    frameExp_t e;
    int        k;
    int        cyc;
    k   = 0;
    cyc = 0;
    @(posedge clk); #1;
    bus.baudrate  = baud[7:0];
    bus.framesize = n[3:0];
    bus.start     = 1'b1;
    if (abortAt < 0) begin
      e = buildFrame(id, baud, n, skipIdx);
      if (litLen > 0) begin
        e.bits  = '0;
        e.nbits = litLen;
        for (int i = 0; i < litLen; i++) e.bits[i] = lit[litLen-1-i];
      end
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput($sformatf("busyAfterStart[f%0d]", id), bus.busy, 1);
    checkOutput($sformatf("txStartBit[f%0d]", id), bus.TX, 1);
    while (bus.busy && cyc < 4000) begin
      bus.framesize = bus.framesize + 4'd5;
      bus.start     = poke && (cyc % 7 == 3);
      if (k == skipIdx && bus.ur) k++;
      if (bus.dready && k < n && k != skipIdx) begin
        bus.dvalid = 1'b1;
        bus.datain = txBytes[k];
        k++;
      end else begin
        bus.dvalid = 1'b0;
      end
      if (cyc == abortAt) begin
        bus.start = 1'b0;
        reset     = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        reset      = 1'b0;
        bus.dvalid = 1'b0;
        checkOutput($sformatf("busyAfterAbort[f%0d]", id), bus.busy, 0);
        checkOutput($sformatf("txAfterAbort[f%0d]", id), bus.TX, 0);
        checkOutput($sformatf("dreadyAfterAbort[f%0d]", id), bus.dready, 0);
        checkOutput($sformatf("doneAfterAbort[f%0d]", id), bus.done, 0);
        break;
      end
    end
    bus.dvalid = 1'b0;
    bus.start  = 1'b0;
    if (cyc >= 4000) begin
      checkOutput($sformatf("frameTimeout[f%0d]", id), bus.busy, 0);
    end else if (abortAt < 0) begin
      checkOutput($sformatf("doneAtBusyFall[f%0d]", id), bus.done, 1);
      if (poke) begin
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput($sformatf("startInDoneIgnored[f%0d]", id), bus.busy, 0);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset         = 1'b1;
    bus.baudrate  = '0;
    bus.start     = 1'b0;
    bus.framesize = '0;
    bus.datain    = '0;
    bus.dvalid    = 1'b0;
    for (int i = 0; i < 16; i++) txBytes[i] = 8'h00;
    repeat (3) @(posedge clk); #1;
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetTx", bus.TX, 0);
    checkOutput("resetDready", bus.dready, 0);
    checkOutput("resetDone", bus.done, 0);
    checkOutput("resetUr", bus.ur, 0);
    reset = 1'b0;

    // Empty frame, 4 clocks per bit, start poked mid-frame and in the done cycle.
    applyStimulus(1, 4, 0, -1, -1, 1'b1, 14, 256'(14'b1_0000_00000000_0));

    // One 0xFF byte at one clock per bit; CRC over 0001_11111111 is 0xE6.
    txBytes[0] = 8'hFF;
`ifdef TX_BITSTUFF_EN
    applyStimulus(2, 1, 1, -1, -1, 1'b0, 24, 256'(24'b1_0001_11110_1111_101100110_0));
`else
    applyStimulus(2, 1, 1, -1, -1, 1'b0, 22, 256'(22'b1_0001_11111111_11100110_0));
`endif

    // Second of three bytes withheld: sent as 0x00 and ur raised.
    txBytes[0] = 8'hA5; txBytes[1] = 8'h77; txBytes[2] = 8'h3C;
    applyStimulus(3, 2, 3, 1, -1, 1'b0, 0, '0);
    checkOutput("urStickyInIdle", bus.ur, 1);

    // Normal frame clears ur on its start; mid-frame start pokes ignored.
    txBytes[0] = 8'h12; txBytes[1] = 8'h34;
    applyStimulus(4, 3, 2, -1, -1, 1'b1, 0, '0);

    // Reset during DATA aborts with no done; the next frame is clean.
    txBytes[0] = 8'hDE; txBytes[1] = 8'hAD; txBytes[2] = 8'hBE; txBytes[3] = 8'hEF;
    applyStimulus(5, 2, 4, -1, 30, 1'b0, 0, '0);
    txBytes[0] = 8'h81;
    applyStimulus(6, 2, 1, -1, -1, 1'b0, 0, '0);

    // baudrate 0 and 1 must give the same waveform.
    txBytes[0] = 8'h5A; txBytes[1] = 8'hC3;
    applyStimulus(7, 0, 2, -1, -1, 1'b0, 0, '0);
    applyStimulus(8, 1, 2, -1, -1, 1'b0, 0, '0);

    // Fifteen back-to-back bytes with no inter-byte gap.
    for (int i = 0; i < 15; i++) txBytes[i] = 8'(i * 17 + 3);
    applyStimulus(9, 1, 15, -1, -1, 1'b0, 0, '0);

    repeat (5) @(posedge clk); #1;
    checkOutput("pendingFrames", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
